// File: rtl/stack_alu_pkg.sv
// Shared types for the RPN stack-ALU sequencer: ALU opcodes, token kinds,
// result codes and the sequencer FSM state.
package stack_alu_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned KIND_W = 2;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP  = 3'b000,
        OPC_ADD  = 3'b100,
        OPC_MUL  = 3'b101,
        OPC_PUSH = 3'b110,
        OPC_POP  = 3'b111
    } alu_opcode_e;

    typedef enum logic [KIND_W-1:0] {
        TOK_OPERAND = 2'b00,
        TOK_ADD     = 2'b01,
        TOK_MUL     = 2'b10,
        TOK_END     = 2'b11
    } tok_kind_e;

    typedef enum logic [CODE_W-1:0] {
        RES_OK       = 2'b00,
        RES_OVERFLOW = 2'b01,
        RES_DEPTH    = 2'b10,
        RES_FULL     = 2'b11
    } res_code_e;

    typedef enum logic [2:0] {
        ST_INIT_DRAIN,
        ST_FETCH,
        ST_EXEC,
        ST_CHECK,
        ST_FLUSH,
        ST_DRAIN,
        ST_REPORT
    } seq_state_e;

    // The first error of an expression wins.
    function automatic res_code_e sticky_code(input res_code_e cur, input res_code_e nxt);
        return (cur == RES_OK) ? nxt : cur;
    endfunction

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Token, ALU and result signals of the sequencer; slave is the sequencer view,
// master is the environment (token source, ALU, result sink) view.
interface stack_alu_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import stack_alu_pkg::*;

    logic                  tok_valid;
    logic                  tok_ready;
    tok_kind_e             tok_kind;
    logic [DATA_WIDTH-1:0] tok_data;
    alu_opcode_e           alu_opcode;
    logic [DATA_WIDTH-1:0] alu_data;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_overflow;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    res_code_e             res_code;

    modport slave (
        input  tok_valid, tok_kind, tok_data, alu_result, alu_overflow,
        output tok_ready, alu_opcode, alu_data, res_valid, res_data, res_code
    );

    modport master (
        output tok_valid, tok_kind, tok_data, alu_result, alu_overflow,
        input  tok_ready, alu_opcode, alu_data, res_valid, res_data, res_code
    );

endinterface

// File: rtl/stack_depth_tracker.sv
// Shadow copy of the ALU stack depth, with registered empty/full/ge2 flags
// that always agree with the registered depth.
module stack_depth_tracker #(
    parameter int unsigned STACK_SIZE = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              inc_i,
    input  logic                              dec_i,
    output logic [$clog2(STACK_SIZE+1)-1:0]   depth_o,
    output logic                              empty_o,
    output logic                              full_o,
    output logic                              ge2_o
);
    localparam int unsigned DEPTH_W = $clog2(STACK_SIZE + 1);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               empty_q, full_q, ge2_q;

    // Saturating up/down count.
    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && (depth_q != DEPTH_W'(STACK_SIZE))) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec_i && !inc_i && (depth_q != '0)) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ge2_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            empty_q <= (depth_d == '0);
            full_q  <= (depth_d == DEPTH_W'(STACK_SIZE));
            ge2_q   <= (depth_d >= DEPTH_W'(2));
        end
    end

    assign depth_o = depth_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign ge2_o   = ge2_q;

endmodule

// File: rtl/stack_alu_sequencer.sv
// Feeds RPN tokens to an external stack ALU, predicts depth errors with a
// shadow counter, checks ALU overflow and reports one result per expression.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STACK_SIZE = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    stack_alu_sequencer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(STACK_SIZE + 1);

    seq_state_e            state_q;
    logic [CNT_W-1:0]      drain_cnt_q;
    alu_opcode_e           alu_opcode_q;
    logic [DATA_WIDTH-1:0] alu_data_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic                  tok_ready_q;
    logic                  res_valid_q;
    logic                  is_end_q;
    res_code_e             res_code_q;

    logic                  hs_c, inc_c, dec_c;
    alu_opcode_e           fetch_op_c;
    res_code_e             fetch_err_c;
    logic [CNT_W-1:0]      depth;
    logic                  depth_empty, depth_full, depth_ge2;

    assign hs_c = bus.tok_valid && tok_ready_q;

    // Opcode a fetched token maps to, or the error it is predicted to cause.
    always_comb begin
        fetch_op_c  = OPC_NOP;
        fetch_err_c = RES_OK;
        case (bus.tok_kind)
            TOK_OPERAND: if (depth_full) fetch_err_c = RES_FULL;  else fetch_op_c = OPC_PUSH;
            TOK_ADD:     if (!depth_ge2) fetch_err_c = RES_DEPTH; else fetch_op_c = OPC_ADD;
            TOK_MUL:     if (!depth_ge2) fetch_err_c = RES_DEPTH; else fetch_op_c = OPC_MUL;
            TOK_END:     if (depth != CNT_W'(1)) fetch_err_c = RES_DEPTH; else fetch_op_c = OPC_POP;
        endcase
    end

    // Shadow depth moves only with opcodes actually issued after init.
    always_comb begin
        inc_c = 1'b0;
        dec_c = 1'b0;
        if ((state_q == ST_FETCH) && hs_c) begin
            inc_c = (fetch_op_c == OPC_PUSH);
            dec_c = (fetch_op_c inside {OPC_ADD, OPC_MUL, OPC_POP});
        end else if (state_q == ST_DRAIN) begin
            dec_c = !depth_empty;
        end
    end

    stack_depth_tracker #(
        .STACK_SIZE (STACK_SIZE)
    ) u_depth (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_c),
        .dec_i   (dec_c),
        .depth_o (depth),
        .empty_o (depth_empty),
        .full_o  (depth_full),
        .ge2_o   (depth_ge2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT_DRAIN;
            drain_cnt_q  <= '0;
            alu_opcode_q <= OPC_NOP;
            alu_data_q   <= '0;
            tok_ready_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_code_q   <= RES_OK;
            is_end_q     <= 1'b0;
        end else begin
            alu_opcode_q <= OPC_NOP;
            res_valid_q  <= 1'b0;
            case (state_q)
                // The ALU stack has no reset: pop it empty blindly.
                ST_INIT_DRAIN: begin
                    if (drain_cnt_q == CNT_W'(STACK_SIZE)) begin
                        state_q     <= ST_FETCH;
                        tok_ready_q <= 1'b1;
                    end else begin
                        alu_opcode_q <= OPC_POP;
                        drain_cnt_q  <= drain_cnt_q + CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (hs_c) begin
                        is_end_q <= (bus.tok_kind == TOK_END);
                        if (fetch_err_c != RES_OK) begin
                            res_code_q <= sticky_code(res_code_q, fetch_err_c);
                            if (bus.tok_kind == TOK_END) begin
                                state_q     <= ST_DRAIN;
                                tok_ready_q <= 1'b0;
                            end else begin
                                state_q <= ST_FLUSH;
                            end
                        end else begin
                            alu_opcode_q <= fetch_op_c;
                            if (bus.tok_kind == TOK_OPERAND) alu_data_q <= bus.tok_data;
                            state_q     <= ST_EXEC;
                            tok_ready_q <= 1'b0;
                        end
                    end
                end
                ST_EXEC: state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (bus.alu_overflow) begin
                        res_code_q <= sticky_code(res_code_q, RES_OVERFLOW);
                        if (is_end_q) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q     <= ST_FLUSH;
                            tok_ready_q <= 1'b1;
                        end
                    end else if (is_end_q) begin
                        res_data_q  <= bus.alu_result;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_REPORT;
                    end else begin
                        state_q     <= ST_FETCH;
                        tok_ready_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (hs_c && (bus.tok_kind == TOK_END)) begin
                        state_q     <= ST_DRAIN;
                        tok_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!depth_empty) begin
                        alu_opcode_q <= OPC_POP;
                    end else begin
                        res_data_q  <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    res_code_q  <= RES_OK;
                    res_data_q  <= '0;
                    is_end_q    <= 1'b0;
                    state_q     <= ST_FETCH;
                    tok_ready_q <= 1'b1;
                end
                default: state_q <= ST_INIT_DRAIN;
            endcase
        end
    end

    assign bus.tok_ready  = tok_ready_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_data   = alu_data_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_code   = res_code_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack ALU with signed overflow,
// directed RPN cases plus random expressions against a queue-based RPN model.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned SS   = 64;
    localparam int          SMAX = (1 << (DW - 1)) - 1;
    localparam int          SMIN = -(1 << (DW - 1));

    typedef struct {
        logic [1:0]    kind;
        logic [DW-1:0] data;
    } tok_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_alu_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    stack_alu_sequencer #(
        .DATA_WIDTH (DW),
        .STACK_SIZE (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop = 0, n_push = 0, n_add = 0, n_res = 0;
    bit rand_gaps = 1'b0;
    tok_s cur[$];
    logic [1:0]    last_c;
    logic [DW-1:0] last_d;

    // Stack ALU without reset; starts with garbage, flags signed overflow.
    logic [DW-1:0] alu_mem [SS];
    int            alu_sp;
    bit            alu_init = 1'b0;
    logic [DW-1:0] alu_res_q;
    logic          alu_ovf_q;
    assign bus.alu_result   = alu_res_q;
    assign bus.alu_overflow = alu_ovf_q;

    always @(posedge clk) begin : alu_model
        int a, b, r;
        if (!alu_init) begin
            alu_sp = $urandom_range(1, SS);
            for (int i = 0; i < SS; i++) alu_mem[i] = DW'($urandom);
            alu_init = 1'b1;
        end
        alu_ovf_q <= 1'b0;
        case (bus.alu_opcode)
            OPC_PUSH: if (alu_sp < SS) begin
                alu_mem[alu_sp] = bus.alu_data;
                alu_sp = alu_sp + 1;
                alu_res_q <= bus.alu_data;
            end
            OPC_POP: if (alu_sp > 0) begin
                alu_sp = alu_sp - 1;
                alu_res_q <= alu_mem[alu_sp];
            end
            OPC_ADD, OPC_MUL: if (alu_sp >= 2) begin
                a = int'($signed(alu_mem[alu_sp-2]));
                b = int'($signed(alu_mem[alu_sp-1]));
                r = (bus.alu_opcode == OPC_ADD) ? a + b : a * b;
                alu_sp = alu_sp - 1;
                alu_mem[alu_sp-1] = DW'(r);
                alu_res_q <= DW'(r);
                alu_ovf_q <= (r > SMAX) || (r < SMIN);
            end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            case (bus.alu_opcode)
                OPC_POP:  n_pop++;
                OPC_PUSH: n_push++;
                OPC_ADD:  n_add++;
                default:  ;
            endcase
            if (bus.res_valid) n_res++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_tok(input logic [1:0] k, input logic [DW-1:0] d);
        tok_s t;
        t.kind = k;
        t.data = d;
        cur.push_back(t);
    endtask

    function automatic int wrap_s(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return int'($signed(t));
    endfunction

    // RPN evaluation with the error rules; pops = ALU pops expected.
    function automatic void ref_eval(input tok_s toks[$], output logic [1:0] code,
                                     output logic [DW-1:0] data, output int pops);
        int stk[$];
        int a, b, r;
        code = 2'b00;
        data = '0;
        pops = 0;
        foreach (toks[i]) begin
            if (code != 2'b00) continue;
            case (toks[i].kind)
                2'd0: if (stk.size() == SS) code = 2'b11;
                      else stk.push_back(int'($signed(toks[i].data)));
                2'd1, 2'd2: if (stk.size() < 2) code = 2'b10;
                      else begin
                          b = stk.pop_back();
                          a = stk.pop_back();
                          r = (toks[i].kind == 2'd1) ? a + b : a * b;
                          stk.push_back(wrap_s(r));
                          if (r > SMAX || r < SMIN) code = 2'b01;
                      end
                default: if (stk.size() != 1) code = 2'b10;
                      else begin
                          data = DW'(stk.pop_back());
                          pops = 1;
                      end
            endcase
        end
        if (code != 2'b00) data = '0;
        pops += stk.size();
    endfunction

    task automatic send_tok(input tok_s t, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        bus.tok_valid = 1'b1;
        bus.tok_kind  = tok_kind_e'(t.kind);
        bus.tok_data  = t.data;
        while (bus.tok_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                ok = 1'b0;
                break;
            end
        end
        if (ok) @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic wait_result(output int edges, output logic got,
                               output logic [DW-1:0] d, output logic [1:0] c);
        edges = 0;
        got   = 1'b0;
        d     = '0;
        c     = '0;
        while (edges < 300) begin
            @(negedge clk);
            edges++;
            if (bus.res_valid === 1'b1) begin
                got = 1'b1;
                d   = bus.res_data;
                c   = bus.res_code;
                break;
            end
        end
    endtask

    task automatic run_expr(input string tag);
        logic [1:0]    ec, c;
        logic [DW-1:0] ed, d;
        int            ep, pop0, res0, edges;
        logic          ok, all_ok, got;
        ref_eval(cur, ec, ed, ep);
        pop0   = n_pop;
        res0   = n_res;
        all_ok = 1'b1;
        foreach (cur[i]) begin
            if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_tok(cur[i], ok);
            all_ok &= ok;
        end
        check({tag, " tokens accepted"}, 32'(all_ok), 32'(1));
        wait_result(edges, got, d, c);
        check({tag, " res_valid"}, 32'(got), 32'(1));
        check({tag, " res_code"}, 32'(c), 32'(ec));
        check({tag, " res_data"}, 32'(d), 32'(ed));
        if (ec == 2'b00) check({tag, " latency"}, 32'(edges), 32'(3));
        @(negedge clk);
        check({tag, " res_valid width"}, 32'(bus.res_valid), 32'(0));
        check({tag, " tok_ready after report"}, 32'(bus.tok_ready), 32'(1));
        check({tag, " pops"}, 32'(n_pop - pop0), 32'(ep));
        check({tag, " reports"}, 32'(n_res - res0), 32'(1));
        last_c = c;
        last_d = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " alu_opcode"}, 32'(bus.alu_opcode), 32'(0));
        check({tag, " alu_data"},   32'(bus.alu_data),   32'(0));
        check({tag, " tok_ready"},  32'(bus.tok_ready),  32'(0));
        check({tag, " res_valid"},  32'(bus.res_valid),  32'(0));
        check({tag, " res_data"},   32'(bus.res_data),   32'(0));
        check({tag, " res_code"},   32'(bus.res_code),   32'(0));
    endtask

    task automatic check_init_drain(input string tag);
        int pops, n;
        pops = 0;
        n    = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus.alu_opcode == OPC_POP) pops++;
            else if (pops > 0) break;
        end
        check({tag, " pop cycles"}, 32'(pops), 32'(SS));
        check({tag, " nop after drain"}, 32'(bus.alu_opcode), 32'(OPC_NOP));
        check({tag, " tok_ready"}, 32'(bus.tok_ready), 32'(1));
    endtask

    initial begin
        int   add0, push0, res0, nt, r;
        logic ok;
        bus.tok_valid = 1'b0;
        bus.tok_kind  = TOK_OPERAND;
        bus.tok_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        check_init_drain("init");

        cur.delete();
        add_tok(0, 3); add_tok(0, 4); add_tok(1, 0); add_tok(0, 5); add_tok(2, 0); add_tok(3, 0);
        run_expr("rpn35");
        check("rpn35 const data", 32'(last_d), 32'(35));
        check("rpn35 const code", 32'(last_c), 32'(0));

        cur.delete();
        add_tok(0, 100); add_tok(0, 100); add_tok(1, 0); add_tok(3, 0);
        run_expr("ovf");
        check("ovf const code", 32'(last_c), 32'(1));

        cur.delete();
        add0  = n_add;
        push0 = n_push;
        add_tok(1, 0); add_tok(0, 7); add_tok(3, 0);
        run_expr("early_add");
        check("early_add const code", 32'(last_c), 32'(2));
        check("early_add no add op", 32'(n_add - add0), 32'(0));
        check("early_add 7 flushed", 32'(n_push - push0), 32'(0));

        cur.delete();
        add_tok(0, 1); add_tok(0, 2); add_tok(3, 0);
        run_expr("two_left");
        check("two_left const code", 32'(last_c), 32'(2));

        cur.delete();
        for (int i = 0; i < SS + 1; i++) add_tok(0, DW'(i));
        add_tok(3, 0);
        run_expr("full");
        check("full const code", 32'(last_c), 32'(3));

        rand_gaps = 1'b1;
        for (int e = 0; e < 30; e++) begin
            cur.delete();
            nt = $urandom_range(1, 8);
            for (int i = 0; i < nt; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6) add_tok(0, ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 9)) : DW'($urandom));
                else if (r < 8) add_tok(1, 0);
                else add_tok(2, 0);
            end
            add_tok(3, 0);
            run_expr($sformatf("rand%0d", e));
        end
        rand_gaps = 1'b0;

        // Reset while the second push is executing.
        cur.delete();
        add_tok(0, 1); add_tok(0, 2);
        res0 = n_res;
        foreach (cur[i]) send_tok(cur[i], ok);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_init_drain("reinit");
        check("mid_rst no report", 32'(n_res - res0), 32'(0));

        cur.delete();
        add_tok(0, 6); add_tok(0, 7); add_tok(2, 0); add_tok(3, 0);
        run_expr("after_rst");
        check("after_rst const data", 32'(last_d), 32'(42));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
